// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared combinational ALU.
// The arbiter takes the slave view; the requesters/ALU side takes the master view.
interface alu_arbiter_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CTRL_W = 4;

    logic              req_valid_0;
    logic              req_valid_1;
    logic              req_ready_0;
    logic              req_ready_1;
    logic [CTRL_W-1:0] req_ctrl_0;
    logic [CTRL_W-1:0] req_ctrl_1;
    logic [DATA_W-1:0] req_rd_0;
    logic [DATA_W-1:0] req_rd_1;
    logic [DATA_W-1:0] req_rs_0;
    logic [DATA_W-1:0] req_rs_1;
    logic              resp_valid_0;
    logic              resp_valid_1;
    logic [DATA_W-1:0] resp_data_0;
    logic [DATA_W-1:0] resp_data_1;
    logic              resp_ready_0;
    logic              resp_ready_1;
    logic [DATA_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_rs;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_out;
    logic              busy;

    modport slave (
        input  req_valid_0, req_valid_1, req_ctrl_0, req_ctrl_1,
        input  req_rd_0, req_rd_1, req_rs_0, req_rs_1,
        input  resp_ready_0, resp_ready_1, alu_out,
        output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
        output resp_data_0, resp_data_1, alu_rd, alu_rs, alu_ctrl, busy
    );

    modport master (
        output req_valid_0, req_valid_1, req_ctrl_0, req_ctrl_1,
        output req_rd_0, req_rd_1, req_rs_0, req_rs_1,
        output resp_ready_0, resp_ready_1, alu_out,
        input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
        input  resp_data_0, resp_data_1, alu_rd, alu_rs, alu_ctrl, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One operation in flight: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic          clock,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CTRL_W    = 4;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              req_any;
    logic              win;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            ctrl_q   <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        ctrl_d   = ctrl_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        result_d = result_q;

        bus.req_ready_0  = 1'b0;
        bus.req_ready_1  = 1'b0;
        bus.resp_valid_0 = 1'b0;
        bus.resp_valid_1 = 1'b0;
        bus.resp_data_0  = '0;
        bus.resp_data_1  = '0;
        bus.alu_ctrl     = CTRL_IDLE;
        bus.alu_rd       = rd_q;
        bus.alu_rs       = rs_q;
        bus.busy         = (state_q != IDLE);

        // Tie goes to the pointer (or to requester 0 in fixed mode); otherwise the lone requester.
        req_any = bus.req_valid_0 | bus.req_valid_1;
        win     = (bus.req_valid_0 && bus.req_valid_1) ? (RR_EN ? ptr_q : 1'b0)
                                                       : ~bus.req_valid_0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    bus.req_ready_0 = ~win;
                    bus.req_ready_1 = win;
                    owner_d = win;
                    ctrl_d  = win ? bus.req_ctrl_1 : bus.req_ctrl_0;
                    rd_d    = win ? bus.req_rd_1   : bus.req_rd_0;
                    rs_d    = win ? bus.req_rs_1   : bus.req_rs_0;
                    if (RR_EN) ptr_d = ~win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bus.alu_ctrl = ctrl_q;
                result_d     = bus.alu_out;
                state_d      = RESP;
            end
            RESP: begin
                bus.resp_valid_0 = ~owner_q;
                bus.resp_valid_1 = owner_q;
                bus.resp_data_0  = owner_q ? '0 : result_q;
                bus.resp_data_1  = owner_q ? result_q : '0;
                if (owner_q ? bus.resp_ready_1 : bus.resp_ready_0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keep every handshake output quiet while reset is held.
        if (!reset_n) begin
            bus.req_ready_0  = 1'b0;
            bus.req_ready_1  = 1'b0;
            bus.resp_valid_0 = 1'b0;
            bus.resp_valid_1 = 1'b0;
            bus.resp_data_0  = '0;
            bus.resp_data_1  = '0;
            bus.alu_ctrl     = CTRL_IDLE;
            bus.busy         = 1'b0;
        end
    end
endmodule
